// File: rtl/rep_serial_tx.sv
// Bit-serial repetition-code transmitter: sends a parallel word LSB-first,
// repeating every bit REP beats, with valid/ready handshakes on both sides.
module rep_serial_tx #(
  parameter int WIDTH = 8,
  parameter int REP   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_bit,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (REP > 1) ? $clog2(REP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]    rep_cnt_q, rep_cnt_d;

  logic send;
  logic beat;
  logic accept;

  assign send     = (state_q == SEND);
  assign tx_valid = send;
  assign tx_bit   = send & shift_q[0];
  assign tx_last  = send & (bit_cnt_q == BIT_LAST) & (rep_cnt_q == REP_LAST);
  // A word can be taken on the final beat itself, so words run back to back.
  assign in_ready = ~rst & (~send | (tx_last & tx_ready));
  assign beat     = send & tx_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;

    if (beat) begin
      if (rep_cnt_q == REP_LAST) begin
        rep_cnt_d = '0;
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (tx_last) begin
          state_d = IDLE;
        end
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end

    if (accept) begin
      state_d   = SEND;
      shift_d   = in_data;
      bit_cnt_d = '0;
      rep_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: tb/tb_rep_serial_tx.sv
// Bench for rep_serial_tx: scenario tasks compare the accepted beat stream
// against a word-level repetition model; two WIDTH=1 instances cover corners.
module tb_rep_serial_tx;
  localparam int W = 8;
  localparam int R = 5;
  localparam int N = W * R;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid, in_ready, tx_bit, tx_valid, tx_ready, tx_last;

  logic [0:0] c_data;
  logic       c_valid, c_txr;
  logic       i1_ready, b1, v1, l1;
  logic       i3_ready, b3, v3, l3;

  rep_serial_tx #(.WIDTH(W), .REP(R)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last));

  rep_serial_tx #(.WIDTH(1), .REP(1)) dut_w1r1 (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid),
    .in_ready(i1_ready), .tx_bit(b1), .tx_valid(v1),
    .tx_ready(c_txr), .tx_last(l1));

  rep_serial_tx #(.WIDTH(1), .REP(3)) dut_w1r3 (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid),
    .in_ready(i3_ready), .tx_bit(b3), .tx_valid(v3),
    .tx_ready(c_txr), .tx_last(l3));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_on = 1'b0;

  logic mon_bits[$];
  logic mon_last[$];
  logic mon_inrdy[$];
  int   mon_cyc[$];
  logic exp_bits[$];
  logic exp_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted beat of the main instance.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      mon_bits.push_back(tx_bit);
      mon_last.push_back(tx_last);
      mon_inrdy.push_back(in_ready);
      mon_cyc.push_back(cyc);
    end
  end

  // Reference: each bit of the word, LSB first, repeated R times; last on the final copy.
  function automatic void model_add_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++)
      for (int r = 0; r < R; r++) begin
        exp_bits.push_back(w[i]);
        exp_last.push_back((i == W - 1) && (r == R - 1));
      end
  endfunction

  task automatic clear_all();
    mon_bits.delete(); mon_last.delete(); mon_inrdy.delete(); mon_cyc.delete();
    exp_bits.delete(); exp_last.delete();
  endtask

  // Present a word until it is accepted; returns at the edge of acceptance + 1.
  task automatic offer(input logic [W-1:0] w, output bit ok);
    in_valid = 1'b1;
    in_data  = w;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_beats(input int n, input int bound, output int got);
    int k = 0;
    while (mon_bits.size() < n && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    got = mon_bits.size();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; tx_ready = 1'b0;
    c_valid = 1'b0; c_data = '0; c_txr = 1'b1;
    #2;
    checks++;
    if ({tx_valid, tx_bit, tx_last, in_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got v/b/l/rdy=%b want 0000", {tx_valid, tx_bit, tx_last, in_ready});
    end
    checks++;
    if ({v1, l1, i1_ready, v3, l3, i3_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_corner got=%b want 000000", {v1, l1, i1_ready, v3, l3, i3_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", in_ready, tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok; int got;
    clear_all();
    tx_ready = 1'b1;
    model_add_word(8'hA5);
    offer(8'hA5, ok);
    in_valid = 1'b0;
    checks++;
    if (!ok || tx_valid !== 1'b1 || tx_bit !== 1'b1) begin
      failures++;
      $display("FAIL single_latency got ok=%0d v=%b b=%b want 1 1 1", ok, tx_valid, tx_bit);
    end
    wait_beats(N, 200, got);
    checks++;
    if (got != N) begin
      failures++;
      $display("FAIL single_count got=%0d want=%0d", got, N);
    end
    for (int i = 0; i < exp_bits.size(); i++) begin
      checks++;
      if (i >= mon_bits.size() || mon_bits[i] !== exp_bits[i] || mon_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL single_beat %0d got bit=%b last=%b want bit=%b last=%b",
                 i + 1, mon_bits[i], mon_last[i], exp_bits[i], exp_last[i]);
      end
    end
    checks++;
    if (got == N && mon_cyc[N-1] - mon_cyc[0] != N - 1) begin
      failures++;
      $display("FAIL single_span got=%0d want=%0d", mon_cyc[N-1] - mon_cyc[0], N - 1);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_after got v=%b want 0", tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2; int got;
    clear_all();
    tx_ready = 1'b1;
    model_add_word(8'hFF);
    model_add_word(8'h00);
    offer(8'hFF, ok1);
    offer(8'h00, ok2);
    in_valid = 1'b0;
    wait_beats(2 * N, 400, got);
    checks++;
    if (!ok1 || !ok2 || got != 2 * N) begin
      failures++;
      $display("FAIL b2b_count got ok=%0d%0d beats=%0d want 11 %0d", ok1, ok2, got, 2 * N);
    end
    for (int i = 0; i < exp_bits.size(); i++) begin
      checks++;
      if (i >= mon_bits.size() || mon_bits[i] !== exp_bits[i] || mon_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL b2b_beat %0d got bit=%b last=%b want bit=%b last=%b",
                 i + 1, mon_bits[i], mon_last[i], exp_bits[i], exp_last[i]);
      end
    end
    if (got == 2 * N) begin
      checks++;
      if (mon_inrdy[N-1] !== 1'b1 || mon_cyc[2*N-1] - mon_cyc[0] != 2 * N - 1) begin
        failures++;
        $display("FAIL b2b_gapless got rdy@40=%b span=%0d want 1 %0d",
                 mon_inrdy[N-1], mon_cyc[2*N-1] - mon_cyc[0], 2 * N - 1);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_after got v=%b want 0", tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok; int got; int k;
    logic sb, sl, stalled;
    clear_all();
    tx_ready = 1'b1;
    model_add_word(8'h3C);
    offer(8'h3C, ok);
    in_valid = 1'b1;
    in_data = 8'h99;
    stalled = 1'b0; sb = 1'b0; sl = 1'b0;
    k = 0;
    while (mon_bits.size() < N && k < 600) begin
      tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (tx_bit !== sb || tx_last !== sl) begin
          failures++;
          $display("FAIL bp_hold got b=%b l=%b want b=%b l=%b", tx_bit, tx_last, sb, sl);
        end
      end
      if (tx_valid) begin
        checks++;
        if (in_ready !== (tx_last & tx_ready)) begin
          failures++;
          $display("FAIL bp_in_ready got=%b want=%b", in_ready, tx_last & tx_ready);
        end
      end
      if (tx_last && tx_ready) in_valid = 1'b0;
      stalled = tx_valid & ~tx_ready;
      sb = tx_bit; sl = tx_last;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    tx_ready = 1'b1;
    got = mon_bits.size();
    checks++;
    if (!ok || got != N) begin
      failures++;
      $display("FAIL bp_count got ok=%0d beats=%0d want 1 %0d", ok, got, N);
    end
    for (int i = 0; i < exp_bits.size(); i++) begin
      checks++;
      if (i >= mon_bits.size() || mon_bits[i] !== exp_bits[i] || mon_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL bp_beat %0d got bit=%b last=%b want bit=%b last=%b",
                 i + 1, mon_bits[i], mon_last[i], exp_bits[i], exp_last[i]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_ignore();
    bit ok; int k; int s;
    clear_all();
    tx_ready = 1'b1;
    model_add_word(8'h01);
    offer(8'h01, ok);
    in_valid = 1'b0;
    k = 0;
    while (mon_bits.size() < N && k < 200) begin
      s = mon_bits.size();
      in_valid = (s >= 1 && s < N - 1);
      in_data = 8'hEE;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok || mon_bits.size() != N) begin
      failures++;
      $display("FAIL busy_count got ok=%0d beats=%0d want 1 %0d", ok, mon_bits.size(), N);
    end
    for (int i = 0; i < exp_bits.size(); i++) begin
      checks++;
      if (i >= mon_bits.size() || mon_bits[i] !== exp_bits[i] || mon_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL busy_beat %0d got bit=%b last=%b want bit=%b last=%b",
                 i + 1, mon_bits[i], mon_last[i], exp_bits[i], exp_last[i]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || mon_bits.size() != N) begin
      failures++;
      $display("FAIL busy_no_capture got v=%b beats=%0d want 0 %0d", tx_valid, mon_bits.size(), N);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok; int got;
    clear_all();
    tx_ready = 1'b1;
    offer(8'h5A, ok);
    in_valid = 1'b0;
    wait_beats(16, 200, got);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || got != 16 || tx_valid !== 1'b0 || tx_last !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_immediate got ok=%0d beats=%0d v=%b l=%b rdy=%b want 1 16 0 0 0",
               ok, got, tx_valid, tx_last, in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_held got rdy=%b v=%b want 0 0", in_ready, tx_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_release got rdy=%b v=%b want 1 0", in_ready, tx_valid);
    end
    @(posedge clk); #1;
    clear_all();
    model_add_word(8'hC3);
    offer(8'hC3, ok);
    in_valid = 1'b0;
    wait_beats(N, 200, got);
    checks++;
    if (!ok || got != N) begin
      failures++;
      $display("FAIL rstmid_next_count got ok=%0d beats=%0d want 1 %0d", ok, got, N);
    end
    for (int i = 0; i < exp_bits.size(); i++) begin
      checks++;
      if (i >= mon_bits.size() || mon_bits[i] !== exp_bits[i] || mon_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL rstmid_beat %0d got bit=%b last=%b want bit=%b last=%b",
                 i + 1, mon_bits[i], mon_last[i], exp_bits[i], exp_last[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok; int got; int nw;
    logic [W-1:0] w;
    clear_all();
    nw = 6;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          tx_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join_none
    for (int j = 0; j < nw; j++) begin
      w = W'($urandom);
      model_add_word(w);
      offer(w, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand_accept word %0d got ok=0 want 1", j);
      end
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_beats(nw * N, 2000, got);
    rand_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tx_ready = 1'b1;
    checks++;
    if (got != nw * N) begin
      failures++;
      $display("FAIL rand_count got=%0d want=%0d", got, nw * N);
    end
    for (int i = 0; i < exp_bits.size(); i++) begin
      checks++;
      if (i >= mon_bits.size() || mon_bits[i] !== exp_bits[i] || mon_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL rand_beat %0d got bit=%b last=%b want bit=%b last=%b",
                 i + 1, mon_bits[i], mon_last[i], exp_bits[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_corners();
    logic d;
    for (int t = 0; t < 2; t++) begin
      d = (t == 1);
      c_data = d;
      c_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (i1_ready !== 1'b1 || i3_ready !== 1'b1) begin
        failures++;
        $display("FAIL corner_ready got r1=%b r3=%b want 1 1", i1_ready, i3_ready);
      end
      @(posedge clk); #1;
      c_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        checks++;
        if (v1 !== (k == 1) || (v1 && (b1 !== d || l1 !== 1'b1))) begin
          failures++;
          $display("FAIL corner_r1 cyc %0d got v=%b b=%b l=%b want v=%b b=%b l=1",
                   k, v1, b1, l1, k == 1, d);
        end
        checks++;
        if (v3 !== (k <= 3) || (v3 && (b3 !== d || l3 !== (k == 3)))) begin
          failures++;
          $display("FAIL corner_r3 cyc %0d got v=%b b=%b l=%b want v=%b b=%b l=%b",
                   k, v3, b3, l3, k <= 3, d, k == 3);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_corners();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
